// File: rtl/trivium_stream_par_if.sv
// Word stream bundle for trivium_stream_par: an input word channel and a
// registered output word channel, both valid/ready.
interface trivium_stream_par_if #(
  parameter int W = 8
);
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] in_dat_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] out_dat_o;

  // Engine side.
  modport slave (
    input  in_valid_i, in_dat_i, out_ready_i,
    output in_ready_o, out_valid_o, out_dat_o
  );

  // Host / data-path side.
  modport master (
    output in_valid_i, in_dat_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_dat_o
  );
endinterface

// File: rtl/trivium_stream_par.sv
// Trivium stream cipher engine producing W keystream bits per clock.
// Handshake: a word moves on a channel at a rising clock edge where both
// valid and ready are high. The output stage is a single register; out_dat_o
// is held while out_valid_o is high and out_ready_i is low.
// start_i reloads key/IV from any state and runs the warm-up on its own.
module trivium_stream_par #(
  parameter int W         = 8,
  parameter int WARMUP    = 1152,
  parameter int MAX_WORDS = 0,
  parameter int CNT_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [79:0]       key_i,
  input  logic [79:0]       iv_i,
  trivium_stream_par_if.slave strm,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  word_cnt_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  localparam int STEPS = WARMUP / W;
  localparam int WC_W  = $clog2(STEPS + 1);

  state_t           state_q, state_d;
  logic [287:0]     s_q;      // s_q[k-1] holds Trivium state bit s(k)
  logic [287:0]     s_load;
  logic [287:0]     s_step;
  logic [W-1:0]     ks;
  logic [WC_W-1:0]  wu_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic [W-1:0]     out_dat_q;
  logic             in_ready;
  logic             accept;
  logic             last_word;

  // Initial state image: key, 13 zeros, IV, 112 zeros, three ones.
  always_comb s_load = {3'b111, 112'b0, iv_i, 13'b0, key_i};

  // W Trivium rounds unrolled; keystream bit j comes from round j.
  always_comb begin
    logic [287:0] s;
    logic t1, t2, t3;
    s  = s_q;
    ks = '0;
    for (int j = 0; j < W; j++) begin
      t1 = s[65] ^ s[92];
      t2 = s[161] ^ s[176];
      t3 = s[242] ^ s[287];
      ks[j] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[90] & s[91]) ^ s[170];
      t2 = t2 ^ (s[174] & s[175]) ^ s[263];
      t3 = t3 ^ (s[285] & s[286]) ^ s[68];
      s = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    end
    s_step = s;
  end

  assign accept    = strm.in_valid_i && in_ready;
  assign last_word = (MAX_WORDS != 0) && (cnt_q == CNT_W'(MAX_WORDS - 1));

  // Next-state and input-ready decode; start_i overrides everything.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: state_d = IDLE;
      INIT: if (wu_q == WC_W'(1)) state_d = RUN;
      RUN: begin
        in_ready = !out_valid_q || strm.out_ready_i;
        if (in_ready && strm.in_valid_i && last_word) state_d = DONE;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (start_i) begin
      state_d  = INIT;
      in_ready = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Cipher state, warm-up counter, word counter and output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q         <= '0;
      wu_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_dat_q   <= '0;
    end else if (start_i) begin
      s_q         <= s_load;
      wu_q        <= WC_W'(STEPS);
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (state_q == INIT) begin
        s_q  <= s_step;
        wu_q <= wu_q - 1'b1;
      end
      if (accept) begin
        s_q         <= s_step;
        out_dat_q   <= strm.in_dat_i ^ ks;
        out_valid_q <= 1'b1;
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end else if (strm.out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign strm.in_ready_o  = in_ready;
  assign strm.out_valid_o = out_valid_q;
  assign strm.out_dat_o   = out_dat_q;
  assign busy_o           = (state_q == INIT);
  assign done_o           = (state_q == DONE);
  assign word_cnt_o       = cnt_q;
  assign state_o          = state_q;

endmodule
